// File: rtl/pixy_spi_pkg.sv
// rtl/pixy_spi_pkg.sv - shared widths, receiver state and opcodes for the host SPI link
package pixy_spi_pkg;

    localparam int OPCODE_W   = 8;
    localparam int OPERAND_W  = 24;
    localparam int FRAME_BITS = 32;
    localparam int COUNT_W    = 6;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

    // Opcodes understood by the step/reset/IPL control decoders
    localparam logic [OPCODE_W-1:0] OP_NOP     = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_STEP    = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_RESET   = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_SET_IPL = 8'h03;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [OPERAND_W-1:0] operand;
    } cmd_t;

    function automatic cmd_t frame_to_cmd(input logic [FRAME_BITS-1:0] frame);
        cmd_t c;
        c.opcode  = frame[FRAME_BITS-1 -: OPCODE_W];
        c.operand = frame[OPERAND_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/spi_command_receiver_if.sv
// rtl/spi_command_receiver_if.sv - command handshake and error pulses toward control logic
interface spi_command_receiver_if;
    import pixy_spi_pkg::*;

    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [OPCODE_W-1:0]  CMD_OPCODE;
    logic [OPERAND_W-1:0] CMD_OPERAND;
    logic                 FRAME_ERROR;
    logic                 OVERRUN;

    modport master (
        output CMD_VALID,
        output CMD_OPCODE,
        output CMD_OPERAND,
        output FRAME_ERROR,
        output OVERRUN,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_OPCODE,
        input  CMD_OPERAND,
        input  FRAME_ERROR,
        input  OVERRUN,
        output CMD_READY
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchronizer with level, rise and fall outputs
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_command_receiver.sv
// rtl/spi_command_receiver.sv - SPI slave that assembles 32-bit host command frames
module spi_command_receiver
    import pixy_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 32
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic                          SPICLK_IN,
    input  logic                          SPISS_IN,
    input  logic                          SPISI_IN,
    spi_command_receiver_if.master        cmd
);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FRAME_BITS);
    localparam logic [COUNT_W-1:0] COUNT_SAT  = COUNT_W'(FRAME_BITS + 1);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic ss_level, ss_rise, ss_fall;
    logic si_level, si_rise_unused, si_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPICLK_IN),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPISS_IN),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_si (
        .clk(CLK_IN), .rst(RESET_IN), .d(SPISI_IN),
        .level(si_level), .rise(si_rise_unused), .fall(si_fall_unused)
    );

    // A select already high at reset release must not look like a fresh rise:
    // wait for the chain to flush, then require one observed low before arming.
    logic [1:0] flush_cnt;
    logic       armed;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else if (flush_cnt != 2'(SYNC_STAGES)) begin
            flush_cnt <= flush_cnt + 2'd1;
        end else if (!ss_level) begin
            armed <= 1'b1;
        end
    end

    rx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  commit_q, commit_d;
    logic                  error_q, error_d;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            count_q  <= '0;
            commit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            commit_q <= commit_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        commit_d = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                shift_d = '0;
                count_d = '0;
                if (ss_rise && armed) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_fall) begin
                    state_d = IDLE;
                    if (count_q == COUNT_FULL) begin
                        commit_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], si_level};
                    if (count_q != COUNT_SAT) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // shift_q still holds the frame during the commit cycle; IDLE clears it on the same edge
    cmd_t new_cmd;
    assign new_cmd = frame_to_cmd(shift_q);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            cmd.CMD_VALID   <= 1'b0;
            cmd.CMD_OPCODE  <= '0;
            cmd.CMD_OPERAND <= '0;
            cmd.FRAME_ERROR <= 1'b0;
            cmd.OVERRUN     <= 1'b0;
        end else begin
            cmd.FRAME_ERROR <= error_q;
            cmd.OVERRUN     <= 1'b0;
            if (commit_q) begin
                if (!cmd.CMD_VALID || cmd.CMD_READY) begin
                    cmd.CMD_OPCODE  <= new_cmd.opcode;
                    cmd.CMD_OPERAND <= new_cmd.operand;
                    cmd.CMD_VALID   <= 1'b1;
                end else begin
                    cmd.OVERRUN <= 1'b1;
                end
            end else if (cmd.CMD_VALID && cmd.CMD_READY) begin
                cmd.CMD_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_command_receiver.sv
// tb/tb_spi_command_receiver.sv - self-checking bench for spi_command_receiver
module tb_spi_command_receiver;

    logic clk = 1'b0;
    logic rst;
    logic spiclk, spiss, spisi;

    spi_command_receiver_if cmd_if ();

    spi_command_receiver #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
        .CLK_IN(clk), .RESET_IN(rst), .SPICLK_IN(spiclk), .SPISS_IN(spiss),
        .SPISI_IN(spisi), .cmd(cmd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] act_q[$];
    int err_cnt  = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_if.CMD_VALID && cmd_if.CMD_READY)
                act_q.push_back({cmd_if.CMD_OPCODE, cmd_if.CMD_OPERAND});
            if (cmd_if.FRAME_ERROR) err_cnt++;
            if (cmd_if.OVERRUN) ovr_cnt++;
            if (cmd_if.FRAME_ERROR && cmd_if.OVERRUN) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic select_start();
        spiss = 1'b1;
        wait_clk(4);
    endtask

    task automatic shift_bits(input logic [63:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spisi = data[i];
            wait_clk(4);
            spiclk = 1'b1;
            wait_clk(4);
            spiclk = 1'b0;
        end
    endtask

    task automatic deselect();
        wait_clk(4);
        spiss = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] data, input int n);
        select_start();
        shift_bits(data, n);
        deselect();
        wait_clk(10);
    endtask

    task automatic drain();
        cmd_if.CMD_READY = 1'b1;
        wait_clk(1);
        cmd_if.CMD_READY = 1'b0;
        wait_clk(2);
    endtask

    typedef struct {
        int          nbits;
        logic [63:0] data;
        int          exp_frames;
        logic [31:0] exp_frame;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0, e0, o0, lat, nb;
        logic [63:0] rdata;
        logic        held_v;
        logic [31:0] held;
        logic [31:0] exp_q[$];
        int          exp_err, exp_ovr;

        vecs[0] = '{32, 64'hA512_3456, 1, 32'hA512_3456, 0};
        vecs[1] = '{32, 64'h0000_0000, 1, 32'h0000_0000, 0};
        vecs[2] = '{32, 64'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0};
        vecs[3] = '{31, 64'h1234_5678, 0, 32'h0,         1};
        vecs[4] = '{33, 64'h1_2345_6789, 0, 32'h0,       1};
        vecs[5] = '{32, 64'h8000_0001, 1, 32'h8000_0001, 0};

        rst = 1'b1; spiclk = 1'b0; spiss = 1'b0; spisi = 1'b0;
        cmd_if.CMD_READY = 1'b1;
        wait_clk(3);
        check("reset valid",   cmd_if.CMD_VALID,   0);
        check("reset opcode",  cmd_if.CMD_OPCODE,  0);
        check("reset operand", cmd_if.CMD_OPERAND, 0);
        check("reset ferr",    cmd_if.FRAME_ERROR, 0);
        check("reset ovr",     cmd_if.OVERRUN,     0);
        rst = 1'b0;
        wait_clk(10);

        // First frame: latency from SPISS fall to CMD_VALID
        n0 = act_q.size(); e0 = err_cnt; o0 = ovr_cnt; lat = 0;
        select_start();
        shift_bits(64'hA512_3456, 32);
        deselect();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #2;
            if (cmd_if.CMD_VALID && lat == 0) lat = k;
        end
        check("latency", lat, 4);
        check("first count", act_q.size() - n0, 1);
        if (act_q.size() > n0) check("first frame", act_q[act_q.size()-1], 32'hA512_3456);
        check("first errs", (err_cnt - e0) + (ovr_cnt - o0), 0);

        // Short and long frames
        n0 = act_q.size(); e0 = err_cnt;
        send_frame(64'h7FFF_FFFF, 31);
        check("31b ferr", err_cnt - e0, 1);
        send_frame(64'h1_FFFF_FFFF, 33);
        check("33b ferr", err_cnt - e0, 2);
        check("bad frames count", act_q.size() - n0, 0);
        check("bad frames valid", cmd_if.CMD_VALID, 0);

        // Overrun with consumer stalled
        cmd_if.CMD_READY = 1'b0;
        o0 = ovr_cnt;
        send_frame(64'h0100_0001, 32);
        send_frame(64'h0200_0002, 32);
        check("ovr valid",   cmd_if.CMD_VALID,   1);
        check("ovr opcode",  cmd_if.CMD_OPCODE,  8'h01);
        check("ovr operand", cmd_if.CMD_OPERAND, 24'h000001);
        check("ovr pulses",  ovr_cnt - o0, 1);
        n0 = act_q.size();
        drain();
        check("ovr drain", act_q.size() - n0, 1);
        if (act_q.size() > n0) check("ovr drained frame", act_q[act_q.size()-1], 32'h0100_0001);

        // Ready raised exactly on the commit cycle of the second frame
        o0 = ovr_cnt; n0 = act_q.size();
        send_frame(64'h0100_0001, 32);
        select_start();
        shift_bits(64'h03AB_CDEF, 32);
        deselect();
        wait_clk(3);
        cmd_if.CMD_READY = 1'b1;
        wait_clk(1);
        cmd_if.CMD_READY = 1'b0;
        check("swap valid",   cmd_if.CMD_VALID,   1);
        check("swap opcode",  cmd_if.CMD_OPCODE,  8'h03);
        check("swap operand", cmd_if.CMD_OPERAND, 24'hABCDEF);
        check("swap no ovr",  ovr_cnt - o0, 0);
        check("swap old out", act_q.size() - n0, 1);
        if (act_q.size() > n0) check("swap old frame", act_q[act_q.size()-1], 32'h0100_0001);
        drain();
        if (act_q.size() > n0 + 1) check("swap new frame", act_q[act_q.size()-1], 32'h03AB_CDEF);

        // Reset in the middle of a frame while a command is held
        send_frame(64'h1234_5678, 32);
        select_start();
        shift_bits(64'hDEAD, 16);
        rst = 1'b1;
        wait_clk(1);
        check("midrst valid",   cmd_if.CMD_VALID,   0);
        check("midrst opcode",  cmd_if.CMD_OPCODE,  0);
        check("midrst operand", cmd_if.CMD_OPERAND, 0);
        wait_clk(2);
        rst = 1'b0;
        cmd_if.CMD_READY = 1'b1;
        n0 = act_q.size(); e0 = err_cnt;
        shift_bits(64'hBEEF, 16);
        deselect();
        wait_clk(10);
        check("midrst no commit", act_q.size() - n0, 0);
        check("midrst no ferr", err_cnt - e0, 0);
        send_frame(64'hFFFF_FFFF, 32);
        check("postrst count", act_q.size() - n0, 1);
        if (act_q.size() > n0) check("postrst frame", act_q[act_q.size()-1], 32'hFFFF_FFFF);

        // SPICLK activity while deselected is ignored
        n0 = act_q.size(); e0 = err_cnt;
        for (int k = 0; k < 8; k++) begin
            spiclk = 1'b1; wait_clk(4);
            spiclk = 1'b0; wait_clk(4);
        end
        send_frame(64'h7E00_0010, 32);
        check("idle clk count", act_q.size() - n0, 1);
        if (act_q.size() > n0) check("idle clk frame", act_q[act_q.size()-1], 32'h7E00_0010);
        check("idle clk ferr", err_cnt - e0, 0);

        // Table of frames with the consumer always ready
        for (int i = 0; i < 6; i++) begin
            n0 = act_q.size(); e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].nbits);
            check($sformatf("vec%0d count", i), act_q.size() - n0, vecs[i].exp_frames);
            check($sformatf("vec%0d ferr", i), err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].exp_frames == 1 && act_q.size() > n0)
                check($sformatf("vec%0d frame", i), act_q[act_q.size()-1], vecs[i].exp_frame);
        end

        // Random frames against a holding-register model, stalled consumer with random drains
        cmd_if.CMD_READY = 1'b0;
        held_v = 1'b0; held = '0; exp_err = 0; exp_ovr = 0;
        n0 = act_q.size(); e0 = err_cnt; o0 = ovr_cnt;
        for (int f = 0; f < 20; f++) begin
            nb = 32;
            if ($urandom_range(0, 3) == 0) begin
                nb = 30 + $urandom_range(0, 3);
                if (nb >= 32) nb++;
            end
            rdata = {$urandom, $urandom};
            send_frame(rdata, nb);
            if (nb == 32) begin
                if (!held_v) begin
                    held_v = 1'b1;
                    held   = rdata[31:0];
                end else begin
                    exp_ovr++;
                end
            end else begin
                exp_err++;
            end
            if ($urandom_range(0, 1) == 1) begin
                drain();
                if (held_v) begin
                    exp_q.push_back(held);
                    held_v = 1'b0;
                end
            end
        end
        drain();
        if (held_v) exp_q.push_back(held);
        check("rand ferr", err_cnt - e0, exp_err);
        check("rand ovr",  ovr_cnt - o0, exp_ovr);
        check("rand count", act_q.size() - n0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (n0 + i < act_q.size())
                check($sformatf("rand frame%0d", i), act_q[n0 + i], exp_q[i]);
        end

        check("no coincident pulses", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
